// File: rtl/cc_pkg.sv
// Shared cache-controller types, line geometry and address field slicing.
package cc_pkg;

   localparam int CC_LINE_W  = 512;
   localparam int CC_BEAT_W  = 64;
   localparam int CC_BEATS   = 8;
   localparam int CC_ADDR_W  = 32;
   localparam int CC_INDEX_W = 9;
   localparam int CC_TAG_W   = 17;

   typedef logic [CC_ADDR_W-1:0] addr_t;
   typedef logic [2:0]           beat_idx_t;

   typedef enum logic {
      ST_IDLE,
      ST_COLLECT
   } fill_state_e;

   function automatic logic [CC_TAG_W-1:0] get_tag(input addr_t addr);
      return addr[31:15];
   endfunction

   function automatic logic [CC_INDEX_W-1:0] get_index(input addr_t addr);
      return addr[14:6];
   endfunction

   // Critical (first-returned) beat of a WRAP burst.
   function automatic beat_idx_t get_beat(input addr_t addr);
      return addr[5:3];
   endfunction

endpackage

// File: rtl/cc_fifo.sv
// Small synchronous FIFO with registered pointers; head is readable while non-empty.
module cc_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  empty,
   output logic                  full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end

   assign head_data = mem[rd_ptr[PTR_W-1:0]];
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/cc_fill_deserializer.sv
// Reassembles critical-word-first 8-beat R bursts into cache lines for the SRAM write port.
module cc_fill_deserializer
   import cc_pkg::*;
#(
   parameter int ADDR_FIFO_DEPTH = 4,
   parameter int INDEX_WIDTH     = CC_INDEX_W,
   parameter int TAG_WIDTH       = CC_TAG_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   miss_req_valid_i,
   input  logic [31:0]            miss_req_addr_i,
   output logic                   miss_req_ready_o,
   input  logic [63:0]            mem_rdata_i,
   input  logic                   mem_rlast_i,
   input  logic                   mem_rvalid_i,
   input  logic                   mem_rready_i,
   output logic                   beat_ok_o,
   output logic                   fill_valid_o,
   input  logic                   fill_ready_i,
   output logic [INDEX_WIDTH-1:0] fill_index_o,
   output logic [TAG_WIDTH-1:0]   fill_tag_o,
   output logic [511:0]           fill_data_o,
   output logic                   err_o
);

   addr_t       head_addr;
   logic        fifo_empty;
   logic        fifo_full;

   fill_state_e          state_q, state_d;
   beat_idx_t            cnt_q, cnt_d;
   beat_idx_t            start_q, start_d;
   beat_idx_t            word_sel;
   logic [CC_LINE_W-1:0] stage_q, stage_d;
   logic [CC_LINE_W-1:0] line_merged;

   logic beat_acc;
   logic beat_hit;
   logic last_beat;
   logic out_free;
   logic err_set;

   assign beat_acc  = mem_rvalid_i & mem_rready_i;
   assign beat_hit  = beat_acc & !fifo_empty;
   assign last_beat = beat_hit & (cnt_q == 3'd7);
   assign out_free  = !fill_valid_o | fill_ready_i;

   assign miss_req_ready_o = !fifo_full;
   assign beat_ok_o        = !fifo_empty & !((cnt_q == 3'd7) & fill_valid_o & !fill_ready_i);

   cc_fifo #(
      .DATA_WIDTH(32),
      .DEPTH     (ADDR_FIFO_DEPTH)
   ) u_addr_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (miss_req_valid_i & !fifo_full),
      .push_data(miss_req_addr_i),
      .pop      (last_beat),
      .head_data(head_addr),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   // Beat 0 takes its start word straight from the FIFO head; later beats use the latched copy.
   assign word_sel = ((state_q == ST_IDLE) ? get_beat(head_addr) : start_q) + cnt_q;

   always_comb begin
      line_merged = stage_q;
      line_merged[word_sel*CC_BEAT_W +: CC_BEAT_W] = mem_rdata_i;
   end

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = start_q;
      stage_d = stage_q;
      if (beat_hit) begin
         stage_d = line_merged;
         cnt_d   = cnt_q + 3'd1;
         if (state_q == ST_IDLE) begin
            start_d = get_beat(head_addr);
            state_d = ST_COLLECT;
         end
         if (cnt_q == 3'd7) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            stage_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         start_q <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         stage_q <= stage_d;
      end
   end

   // A completed line that finds the output still blocked can only come from a beat forced past
   // beat_ok_o; it is dropped and flagged.
   assign err_set = (beat_acc & fifo_empty)
                  | (beat_hit & (mem_rlast_i != (cnt_q == 3'd7)))
                  | (last_beat & !out_free);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_valid_o <= 1'b0;
         fill_data_o  <= '0;
         fill_tag_o   <= '0;
         fill_index_o <= '0;
         err_o        <= 1'b0;
      end else begin
         if (last_beat && out_free) begin
            fill_valid_o <= 1'b1;
            fill_data_o  <= line_merged;
            fill_tag_o   <= get_tag(head_addr);
            fill_index_o <= get_index(head_addr);
         end else if (fill_ready_i) begin
            fill_valid_o <= 1'b0;
         end
         if (err_set)
            err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cc_fill_deserializer.sv
// Self-checking bench: queue-based line model, directed scenarios plus randomized bursts.
module tb_cc_fill_deserializer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         miss_req_valid_i;
   logic [31:0]  miss_req_addr_i;
   logic         miss_req_ready_o;
   logic [63:0]  mem_rdata_i;
   logic         mem_rlast_i;
   logic         mem_rvalid_i;
   logic         mem_rready_i;
   logic         beat_ok_o;
   logic         fill_valid_o;
   logic         fill_ready_i;
   logic [8:0]   fill_index_o;
   logic [16:0]  fill_tag_o;
   logic [511:0] fill_data_o;
   logic         err_o;

   logic rready_en;

   cc_fill_deserializer #(
      .ADDR_FIFO_DEPTH(4),
      .INDEX_WIDTH    (9),
      .TAG_WIDTH      (17)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .miss_req_valid_i(miss_req_valid_i),
      .miss_req_addr_i (miss_req_addr_i),
      .miss_req_ready_o(miss_req_ready_o),
      .mem_rdata_i     (mem_rdata_i),
      .mem_rlast_i     (mem_rlast_i),
      .mem_rvalid_i    (mem_rvalid_i),
      .mem_rready_i    (mem_rready_i),
      .beat_ok_o       (beat_ok_o),
      .fill_valid_o    (fill_valid_o),
      .fill_ready_i    (fill_ready_i),
      .fill_index_o    (fill_index_o),
      .fill_tag_o      (fill_tag_o),
      .fill_data_o     (fill_data_o),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   // The reorder unit qualifies its ready with beat_ok_o.
   assign mem_rready_i = beat_ok_o & rready_en;

   typedef struct {
      logic [16:0]  tag;
      logic [8:0]   index;
      logic [511:0] data;
   } line_t;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [31:0]  addr_q[$];
   line_t        line_q[$];
   int           mb = 0;
   logic [511:0] cur_line = '0;
   bit           exp_err = 1'b0;

   logic         held_valid = 1'b0;
   logic [511:0] held_data;
   logic [16:0]  held_tag;
   logic [8:0]   held_index;

   // Reference: beat k of a burst lands in word (critical + k) mod 8; 8 beats make a line.
   task automatic model_beat(input logic [63:0] data, input logic rlast);
      int    w;
      line_t ln;
      if (addr_q.size() == 0) begin
         exp_err = 1'b1;
         return;
      end
      w = (int'(addr_q[0][5:3]) + mb) % 8;
      cur_line[64*w +: 64] = data;
      if (rlast != (mb == 7))
         exp_err = 1'b1;
      mb++;
      if (mb == 8) begin
         ln.tag   = addr_q[0] >> 15;
         ln.index = (addr_q[0] >> 6) & 32'h1FF;
         ln.data  = cur_line;
         line_q.push_back(ln);
         void'(addr_q.pop_front());
         mb       = 0;
         cur_line = '0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         held_valid = 1'b0;
      end else begin
         if (mem_rvalid_i && mem_rready_i)
            model_beat(mem_rdata_i, mem_rlast_i);
         if (miss_req_valid_i && miss_req_ready_o)
            addr_q.push_back(miss_req_addr_i);
         if (held_valid && fill_valid_o) begin
            n_checks++;
            if ({fill_data_o, fill_tag_o, fill_index_o} !== {held_data, held_tag, held_index}) begin
               n_fail++;
               $display("FAIL fill_stable: tag=%h idx=%h changed while stalled, held tag=%h idx=%h",
                        fill_tag_o, fill_index_o, held_tag, held_index);
            end
         end
         if (fill_valid_o && fill_ready_i) begin
            n_checks++;
            if (line_q.size() == 0) begin
               n_fail++;
               $display("FAIL fill_unexpected: tag=%h idx=%h delivered, no line expected",
                        fill_tag_o, fill_index_o);
            end else begin
               line_t e;
               e = line_q.pop_front();
               if (fill_tag_o !== e.tag || fill_index_o !== e.index || fill_data_o !== e.data) begin
                  n_fail++;
                  $display("FAIL fill_line: got tag=%h idx=%h data=%h expected tag=%h idx=%h data=%h",
                           fill_tag_o, fill_index_o, fill_data_o, e.tag, e.index, e.data);
               end
            end
         end
         held_valid = fill_valid_o && !fill_ready_i;
         held_data  = fill_data_o;
         held_tag   = fill_tag_o;
         held_index = fill_index_o;
      end
   end

   task automatic do_reset();
      rst_n            = 1'b0;
      miss_req_valid_i = 1'b0;
      miss_req_addr_i  = '0;
      mem_rvalid_i     = 1'b0;
      mem_rlast_i      = 1'b0;
      mem_rdata_i      = '0;
      rready_en        = 1'b1;
      fill_ready_i     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      addr_q.delete();
      line_q.delete();
      mb       = 0;
      cur_line = '0;
      exp_err  = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic push_addr(input logic [31:0] a);
      bit acc;
      int waited;
      acc    = 1'b0;
      waited = 0;
      miss_req_valid_i = 1'b1;
      miss_req_addr_i  = a;
      while (!acc) begin
         @(negedge clk);
         acc = miss_req_ready_o;
         @(posedge clk);
         #1;
         waited++;
         if (!acc && waited > 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: addr %h not accepted in 100 cycles", a);
            break;
         end
      end
      miss_req_valid_i = 1'b0;
   endtask

   // pat != 0 gives beat k the data pat|k; otherwise random. bad_k forces rlast on that beat.
   task automatic send_beats(input int n, input int bad_k, input logic [63:0] pat, input bit rnd);
      for (int i = 0; i < n; i++) begin
         int k;
         int waited;
         bit acc;
         k      = mb;
         waited = 0;
         acc    = 1'b0;
         mem_rdata_i = (pat != 0) ? (pat | 64'(k)) : {$urandom, $urandom};
         mem_rlast_i = (k == 7) || (k == bad_k);
         while (!acc) begin
            mem_rvalid_i = rnd ? ($urandom_range(3) != 0) : 1'b1;
            rready_en    = rnd ? ($urandom_range(4) != 0) : 1'b1;
            if (rnd)
               fill_ready_i = 1'($urandom_range(1));
            @(negedge clk);
            acc = mem_rvalid_i & mem_rready_i;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 200) begin
               n_checks++;
               n_fail++;
               $display("FAIL beat_timeout: beat %0d not accepted in 200 cycles", k);
               mem_rvalid_i = 1'b0;
               rready_en    = 1'b1;
               return;
            end
         end
         mem_rvalid_i = 1'b0;
         rready_en    = 1'b1;
      end
   endtask

   task automatic drain(input string tag);
      fill_ready_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (line_q.size() == 0 && !fill_valid_o)
            break;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (line_q.size() != 0 || fill_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d lines still expected, fill_valid=%b, required 0 and 0",
                  tag, line_q.size(), fill_valid_o);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks += 7;
      if (fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fill_valid: got %b want 0", fill_valid_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
      if (miss_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_miss_ready: got %b want 1", miss_req_ready_o); end
      if (beat_ok_o !== 1'b0) begin n_fail++; $display("FAIL reset_beat_ok: got %b want 0", beat_ok_o); end
      if (fill_data_o !== '0) begin n_fail++; $display("FAIL reset_fill_data: got %h want 0", fill_data_o); end
      if (fill_tag_o !== '0) begin n_fail++; $display("FAIL reset_fill_tag: got %h want 0", fill_tag_o); end
      if (fill_index_o !== '0) begin n_fail++; $display("FAIL reset_fill_index: got %h want 0", fill_index_o); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_aligned();
      logic [63:0] pat;
      pat = 64'hD0D0_0000_0000_0000;
      do_reset();
      push_addr(32'h0001_2340);
      send_beats(7, -1, pat, 1'b0);
      n_checks++;
      if (fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL aligned_early_valid: got %b want 0", fill_valid_o); end
      send_beats(1, -1, pat, 1'b0);
      n_checks += 4;
      if (fill_valid_o !== 1'b1) begin n_fail++; $display("FAIL aligned_valid: got %b want 1", fill_valid_o); end
      if (fill_index_o !== 9'h08D) begin n_fail++; $display("FAIL aligned_index: got %h want 08d", fill_index_o); end
      if (fill_tag_o !== 17'h00002) begin n_fail++; $display("FAIL aligned_tag: got %h want 00002", fill_tag_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL aligned_err: got %b want 0", err_o); end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (fill_data_o[64*i +: 64] !== (pat | 64'(i))) begin
            n_fail++;
            $display("FAIL aligned_word%0d: got %h want %h", i, fill_data_o[64*i +: 64], pat | 64'(i));
         end
      end
      drain("aligned");
   endtask

   task automatic test_cwf();
      logic [63:0] pat;
      pat = 64'hB0B0_0000_0000_0000;
      do_reset();
      push_addr(32'h0000_0068);
      send_beats(8, -1, pat, 1'b0);
      n_checks += 4;
      if (fill_data_o[64*5 +: 64] !== (pat | 64'd0)) begin n_fail++; $display("FAIL cwf_word5: got %h want %h", fill_data_o[64*5 +: 64], pat); end
      if (fill_data_o[64*7 +: 64] !== (pat | 64'd2)) begin n_fail++; $display("FAIL cwf_word7: got %h want %h", fill_data_o[64*7 +: 64], pat | 64'd2); end
      if (fill_data_o[64*0 +: 64] !== (pat | 64'd3)) begin n_fail++; $display("FAIL cwf_word0: got %h want %h", fill_data_o[63:0], pat | 64'd3); end
      if (fill_data_o[64*4 +: 64] !== (pat | 64'd7)) begin n_fail++; $display("FAIL cwf_word4: got %h want %h", fill_data_o[64*4 +: 64], pat | 64'd7); end
      drain("cwf");
   endtask

   task automatic test_back_to_back();
      bit acc;
      do_reset();
      push_addr(32'hABC0_1040);
      push_addr(32'h1234_5698);
      send_beats(8, -1, 64'h0, 1'b0);
      send_beats(7, -1, 64'h0, 1'b0);
      n_checks++;
      if (fill_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b want 1", fill_valid_o); end
      mem_rdata_i  = {$urandom, $urandom};
      mem_rlast_i  = 1'b1;
      mem_rvalid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (beat_ok_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall%0d: beat_ok got %b want 0", i, beat_ok_o); end
         @(posedge clk);
         #1;
      end
      fill_ready_i = 1'b1;
      @(negedge clk);
      acc = mem_rvalid_i & mem_rready_i;
      n_checks++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_release: beat accepted %b want 1", acc); end
      @(posedge clk);
      #1;
      fill_ready_i = 1'b0;
      mem_rvalid_i = 1'b0;
      n_checks++;
      if (fill_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_reload_valid: got %b want 1", fill_valid_o); end
      drain("b2b");
   endtask

   task automatic test_fifo_full();
      bit acc;
      bit seen_ready;
      do_reset();
      for (int i = 0; i < 4; i++)
         push_addr($urandom);
      miss_req_valid_i = 1'b1;
      miss_req_addr_i  = 32'h5555_5540;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready%0d: got %b want 0", i, miss_req_ready_o); end
         @(posedge clk);
         #1;
      end
      fill_ready_i = 1'b1;
      send_beats(8, -1, 64'h0, 1'b0);
      seen_ready = 1'b0;
      acc        = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
         @(negedge clk);
         acc = miss_req_ready_o;
         seen_ready |= acc;
         @(posedge clk);
         #1;
      end
      miss_req_valid_i = 1'b0;
      n_checks += 2;
      if (seen_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_return: got %b want 1", seen_ready); end
      if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_refill: ready got %b want 0", miss_req_ready_o); end
      for (int i = 0; i < 4; i++)
         send_beats(8, -1, 64'h0, 1'b0);
      drain("full");
   endtask

   task automatic test_rlast_err();
      do_reset();
      fill_ready_i = 1'b1;
      push_addr(32'h0F0F_00C8);
      send_beats(3, 3, 64'h0, 1'b0);
      n_checks++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL rlast_err_early: got %b want 0", err_o); end
      send_beats(1, 3, 64'h0, 1'b0);
      n_checks++;
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL rlast_err_set: got %b want 1", err_o); end
      send_beats(4, 3, 64'h0, 1'b0);
      drain("rlast");
      n_checks++;
      if (err_o !== exp_err) begin n_fail++; $display("FAIL rlast_err_sticky: got %b want %b", err_o, exp_err); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      push_addr(32'h7777_0000);
      push_addr(32'h8888_0010);
      send_beats(8, -1, 64'h0, 1'b0);
      send_beats(4, -1, 64'h0, 1'b0);
      do_reset();
      @(negedge clk);
      n_checks += 4;
      if (fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_fill_valid: got %b want 0", fill_valid_o); end
      if (beat_ok_o !== 1'b0) begin n_fail++; $display("FAIL midrst_beat_ok: got %b want 0", beat_ok_o); end
      if (miss_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", miss_req_ready_o); end
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err_o); end
      @(posedge clk);
      #1;
      push_addr(32'h9999_0138);
      send_beats(8, -1, 64'h0, 1'b0);
      drain("midrst");
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(2, 1);
         for (int j = 0; j < n; j++)
            if (addr_q.size() < 4)
               push_addr($urandom);
         send_beats(8, -1, 64'h0, 1'b1);
      end
      for (int r = 0; r < 4 && addr_q.size() > 0; r++)
         send_beats(8, -1, 64'h0, 1'b1);
      drain("random");
      n_checks++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL random_err: got %b want 0", err_o); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_aligned();
      test_cwf();
      test_back_to_back();
      test_fifo_full();
      test_rlast_err();
      test_reset_mid_burst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
